// File: rtl/branch_resolver.sv
// Branch resolver: carries the fetch-stage prediction down to Execute, detects
// mispredictions, redirects fetch and emits a one-cycle-delayed predictor update.
module branch_resolver (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PCF,
    input  logic        PredTakenF,
    input  logic [31:0] PredPCF,
    input  logic        StallD,
    input  logic        StallE,
    input  logic        BranchE,
    input  logic        JumpE,
    input  logic        ZeroE,
    input  logic [31:0] PCE,
    input  logic [31:0] PCTargetE,
    output logic        FlushD,
    output logic        FlushE,
    output logic        RedirectE,
    output logic [31:0] RedirectPC,
    output logic        UpdValid,
    output logic [31:0] UpdPC,
    output logic        UpdTaken,
    output logic [31:0] UpdTarget,
    output logic [15:0] BranchCount,
    output logic [15:0] MispredCount
);

    logic        pred_taken_d_q, pred_taken_d_d;
    logic [31:0] pred_pc_d_q, pred_pc_d_d;
    logic        pred_taken_e_q, pred_taken_e_d;
    logic [31:0] pred_pc_e_q, pred_pc_e_d;
    logic        upd_valid_q;
    logic [31:0] upd_pc_q, upd_target_q;
    logic        upd_taken_q;
    logic [15:0] branch_count_q, branch_count_d;
    logic [15:0] mispred_count_q, mispred_count_d;

    logic actual_taken;
    logic resolve;
    logic mispred;
    logic dir_wrong, target_wrong, false_taken;

    // The fetch PC travels with the instruction itself; only the prediction is carried here.
    logic unused_pcf;
    assign unused_pcf = ^PCF;

    always_comb begin
        actual_taken = JumpE | (BranchE & ZeroE);
        resolve      = (BranchE | JumpE) & ~StallE;
        dir_wrong    = resolve & (actual_taken != pred_taken_e_q);
        target_wrong = resolve & actual_taken & pred_taken_e_q & (PCTargetE != pred_pc_e_q);
        false_taken  = ~BranchE & ~JumpE & pred_taken_e_q;
        mispred      = ~StallE & (dir_wrong | target_wrong | false_taken);
    end

    assign FlushD     = mispred;
    assign FlushE     = mispred;
    assign RedirectE  = mispred;
    assign RedirectPC = actual_taken ? PCTargetE : (PCE + 32'd4);

    // Flush beats stall; otherwise a stalled register simply holds.
    always_comb begin
        pred_taken_d_d = pred_taken_d_q;
        pred_pc_d_d    = pred_pc_d_q;
        if (mispred) begin
            pred_taken_d_d = 1'b0;
            pred_pc_d_d    = 32'd0;
        end else if (!StallD) begin
            pred_taken_d_d = PredTakenF;
            pred_pc_d_d    = PredPCF;
        end

        pred_taken_e_d = pred_taken_e_q;
        pred_pc_e_d    = pred_pc_e_q;
        if (mispred) begin
            pred_taken_e_d = 1'b0;
            pred_pc_e_d    = 32'd0;
        end else if (!StallE) begin
            pred_taken_e_d = pred_taken_d_q;
            pred_pc_e_d    = pred_pc_d_q;
        end
    end

    always_comb begin
        branch_count_d  = branch_count_q;
        mispred_count_d = mispred_count_q;
        if (resolve && (branch_count_q != 16'hFFFF))
            branch_count_d = branch_count_q + 16'd1;
        if (mispred && (mispred_count_q != 16'hFFFF))
            mispred_count_d = mispred_count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pred_taken_d_q  <= 1'b0;
            pred_pc_d_q     <= 32'd0;
            pred_taken_e_q  <= 1'b0;
            pred_pc_e_q     <= 32'd0;
            upd_valid_q     <= 1'b0;
            upd_pc_q        <= 32'd0;
            upd_taken_q     <= 1'b0;
            upd_target_q    <= 32'd0;
            branch_count_q  <= 16'd0;
            mispred_count_q <= 16'd0;
        end else begin
            pred_taken_d_q  <= pred_taken_d_d;
            pred_pc_d_q     <= pred_pc_d_d;
            pred_taken_e_q  <= pred_taken_e_d;
            pred_pc_e_q     <= pred_pc_e_d;
            upd_valid_q     <= resolve;
            branch_count_q  <= branch_count_d;
            mispred_count_q <= mispred_count_d;
            // A predicted-taken non-branch never resolves, so it never trains.
            if (resolve) begin
                upd_pc_q     <= PCE;
                upd_taken_q  <= actual_taken;
                upd_target_q <= PCTargetE;
            end
        end
    end

    assign UpdValid     = upd_valid_q;
    assign UpdPC        = upd_pc_q;
    assign UpdTaken     = upd_taken_q;
    assign UpdTarget    = upd_target_q;
    assign BranchCount  = branch_count_q;
    assign MispredCount = mispred_count_q;

endmodule
